// File: rtl/dram_axi_pkg.sv
// Shared AXI4 constants, command-word layout and FSM state type for the DRAM burst writer.
package dram_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;

    // The len field sits directly above the address field in the command word.
    localparam int unsigned CTRL_LEN_LSB = 32;

    function automatic int unsigned ctrl_len_lsb(input int unsigned addr_w);
        return addr_w;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        AW,
        W,
        B
    } state_e;

endpackage

// File: rtl/dram_burst_writer.sv
// Turns each command from the command FIFO into one AXI4 INCR write burst fed from the data FIFO.
// One transaction at a time; progress count and sticky error flags for the control registers.
module dram_burst_writer
    import dram_axi_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned AXI_ID  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [8+ADDR_W-1:0]        ctrl_dout,
    input  logic                       ctrl_empty,
    output logic                       ctrl_rd_en,
    input  logic [DATA_W/8+DATA_W-1:0] data_dout,
    input  logic                       data_empty,
    output logic                       data_rd_en,
    output logic [3:0]                 m_awid,
    output logic [ADDR_W-1:0]          m_awaddr,
    output logic [7:0]                 m_awlen,
    output logic [2:0]                 m_awsize,
    output logic [1:0]                 m_awburst,
    output logic [3:0]                 m_awcache,
    output logic [2:0]                 m_awprot,
    output logic                       m_awvalid,
    input  logic                       m_awready,
    output logic [DATA_W-1:0]          m_wdata,
    output logic [DATA_W/8-1:0]        m_wstrb,
    output logic                       m_wlast,
    output logic                       m_wvalid,
    input  logic                       m_wready,
    input  logic [1:0]                 m_bresp,
    input  logic                       m_bvalid,
    output logic                       m_bready,
    output logic                       busy,
    output logic [31:0]                burst_cnt,
    output logic                       err_resp,
    output logic                       err_len,
    output logic                       err_4k
);

    localparam int unsigned LEN_LSB   = ctrl_len_lsb(ADDR_W);
    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam logic [8:0]  MAX_LEN_W = 9'(MAX_LEN);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          beat_q, beat_d;
    logic [31:0]         burst_cnt_q, burst_cnt_d;
    logic                err_resp_q, err_resp_d;
    logic                err_len_q, err_len_d;
    logic                err_4k_q, err_4k_d;

    logic [7:0]          cmd_len;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [13:0]         burst_end;
    logic                last_beat;

    assign cmd_len   = ctrl_dout[LEN_LSB +: 8];
    assign cmd_addr  = ctrl_dout[ADDR_W-1:0];
    // Byte offset one past the final beat, relative to the enclosing 4 KB page.
    assign burst_end = {2'b00, addr_q[11:0]} + (14'(len_q) * 14'(STRB_W));
    assign last_beat = (beat_q == len_q - 8'd1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        burst_cnt_d = burst_cnt_q;
        err_resp_d  = err_resp_q;
        err_len_d   = err_len_q;
        err_4k_d    = err_4k_q;
        ctrl_rd_en  = 1'b0;
        data_rd_en  = 1'b0;
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        m_wlast     = 1'b0;
        m_bready    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!ctrl_empty && !rst) begin
                    ctrl_rd_en = 1'b1;
                    addr_d     = cmd_addr;
                    len_d      = cmd_len;
                    beat_d     = '0;
                    if (cmd_len == 8'd0 || {1'b0, cmd_len} > MAX_LEN_W) begin
                        err_len_d = 1'b1;
                    end else begin
                        state_d = AW;
                    end
                end
            end
            AW: begin
                m_awvalid = 1'b1;
                if (m_awready) begin
                    state_d = W;
                    if (burst_end > 14'd4096) begin
                        err_4k_d = 1'b1;
                    end
                end
            end
            W: begin
                m_wvalid   = !data_empty;
                m_wlast    = last_beat;
                data_rd_en = !data_empty && m_wready;
                if (data_rd_en) begin
                    if (last_beat) begin
                        state_d = B;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            B: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    burst_cnt_d = burst_cnt_q + 32'd1;
                    if (m_bresp != AXI_RESP_OKAY) begin
                        err_resp_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            burst_cnt_q <= '0;
            err_resp_q  <= 1'b0;
            err_len_q   <= 1'b0;
            err_4k_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            burst_cnt_q <= burst_cnt_d;
            err_resp_q  <= err_resp_d;
            err_len_q   <= err_len_d;
            err_4k_q    <= err_4k_d;
        end
    end

    assign m_awid    = 4'(AXI_ID);
    assign m_awaddr  = addr_q;
    assign m_awlen   = len_q - 8'd1;
    assign m_awsize  = AXI_SIZE_4B;
    assign m_awburst = AXI_BURST_INCR;
    assign m_awcache = AXI_CACHE_BUF;
    assign m_awprot  = '0;
    assign m_wdata   = data_dout[DATA_W-1:0];
    assign m_wstrb   = data_dout[DATA_W +: STRB_W];
    assign busy      = (state_q != IDLE);
    assign burst_cnt = burst_cnt_q;
    assign err_resp  = err_resp_q;
    assign err_len   = err_len_q;
    assign err_4k    = err_4k_q;

endmodule

// File: tb/tb_dram_burst_writer.sv
// Bench for dram_burst_writer: queue-based FIFOs and AXI slave, transaction-level reference model.
module tb_dram_burst_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] ctrl_dout = '0;
    logic        ctrl_empty = 1'b1;
    logic        ctrl_rd_en;
    logic [35:0] data_dout = '0;
    logic        data_empty = 1'b1;
    logic        data_rd_en;
    logic [3:0]  m_awid;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic [3:0]  m_awcache;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [1:0]  m_bresp = 2'b00;
    logic        m_bvalid = 1'b0;
    logic        m_bready;
    logic        busy;
    logic [31:0] burst_cnt;
    logic        err_resp;
    logic        err_len;
    logic        err_4k;

    dram_burst_writer #(
        .ADDR_W (32),
        .DATA_W (32),
        .MAX_LEN(64),
        .AXI_ID (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl_dout (ctrl_dout),
        .ctrl_empty(ctrl_empty),
        .ctrl_rd_en(ctrl_rd_en),
        .data_dout (data_dout),
        .data_empty(data_empty),
        .data_rd_en(data_rd_en),
        .m_awid    (m_awid),
        .m_awaddr  (m_awaddr),
        .m_awlen   (m_awlen),
        .m_awsize  (m_awsize),
        .m_awburst (m_awburst),
        .m_awcache (m_awcache),
        .m_awprot  (m_awprot),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wlast   (m_wlast),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .busy      (busy),
        .burst_cnt (burst_cnt),
        .err_resp  (err_resp),
        .err_len   (err_len),
        .err_4k    (err_4k)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // External FIFO contents (driver side) and reference copies (model side)
    logic [39:0] cq[$];
    logic [35:0] dq[$];
    logic [39:0] mcmd[$];
    logic [35:0] mdata[$];
    logic [1:0]  rq[$];

    // Reference model state
    bit          m_inflight = 0;
    bit          m_aw_done  = 0;
    int          m_len      = 0;
    logic [31:0] m_addr     = '0;
    int          m_beats    = 0;
    logic [31:0] m_bcnt     = '0;
    bit          m_elen = 0, m_eresp = 0, m_e4k = 0;
    int          aw_count   = 0;
    logic [31:0] last_awaddr = '0;
    int          last_awlen  = 0;
    int          last_beats  = 0;

    // Handshakes seen at the negedge, consumed by the driver after the next posedge
    bit cap_ctrl = 0, cap_data = 0, cap_wlast = 0, cap_b = 0;

    // Slave behaviour knobs
    int p_aw = 100, p_w = 100, p_b = 100;
    bit aw_hold_low = 0;
    bit rand_resp = 0;
    int pend_b = 0;
    int pops_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: check outputs against the model, then advance the model across the coming edge
    initial begin
        bit e_ctrl, e_aw, e_w, e_b;
        logic [39:0] cw;
        int ln;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_inflight = 0; m_aw_done = 0; m_beats = 0; m_len = 0;
                m_bcnt = '0; m_elen = 0; m_eresp = 0; m_e4k = 0;
                cap_ctrl = 0; cap_data = 0; cap_wlast = 0; cap_b = 0;
            end else begin
                e_ctrl = !m_inflight && (mcmd.size() > 0);
                e_aw   = m_inflight && !m_aw_done;
                e_w    = m_inflight && m_aw_done && (m_beats < m_len) && !data_empty;
                e_b    = m_inflight && m_aw_done && (m_beats == m_len);

                chk("ctrl_rd_en", 64'(ctrl_rd_en), 64'(e_ctrl));
                chk("awvalid", 64'(m_awvalid), 64'(e_aw));
                chk("wvalid", 64'(m_wvalid), 64'(e_w));
                chk("data_rd_en", 64'(data_rd_en), 64'(e_w && m_wready));
                chk("bready", 64'(m_bready), 64'(e_b));
                chk("busy", 64'(busy), 64'(m_inflight));
                chk("burst_cnt", 64'(burst_cnt), 64'(m_bcnt));
                chk("err_flags", 64'({err_len, err_resp, err_4k}), 64'({m_elen, m_eresp, m_e4k}));
                if (e_aw) begin
                    chk("awaddr", 64'(m_awaddr), 64'(m_addr));
                    chk("awlen", 64'(m_awlen), 64'(m_len - 1));
                    chk("aw_const", 64'({m_awid, m_awsize, m_awburst, m_awcache, m_awprot}),
                        64'({4'd0, 3'b010, 2'b01, 4'b0011, 3'b000}));
                end
                if (e_w) begin
                    chk("wstrb_wdata", 64'({m_wstrb, m_wdata}), 64'(mdata[0]));
                    chk("wlast", 64'(m_wlast), 64'(m_beats == m_len - 1));
                end

                cap_ctrl  = ctrl_rd_en;
                cap_data  = data_rd_en;
                cap_wlast = m_wvalid && m_wready && m_wlast;
                cap_b     = m_bvalid && m_bready;

                if (e_ctrl) begin
                    cw = mcmd.pop_front();
                    ln = int'(cw[39:32]);
                    if (ln == 0 || ln > 64) begin
                        m_elen = 1;
                    end else begin
                        m_inflight = 1; m_aw_done = 0; m_beats = 0;
                        m_len = ln; m_addr = cw[31:0];
                    end
                end
                if (e_aw && m_awready) begin
                    m_aw_done = 1;
                    aw_count++;
                    last_awaddr = m_addr;
                    last_awlen  = m_len - 1;
                    if (int'(m_addr[11:0]) + 4 * m_len > 4096) m_e4k = 1;
                end
                if (e_w && m_wready) begin
                    void'(mdata.pop_front());
                    m_beats++;
                end
                if (e_b && m_bvalid) begin
                    m_bcnt = m_bcnt + 32'd1;
                    if (m_bresp != 2'b00) m_eresp = 1;
                    last_beats = m_beats;
                    m_inflight = 0;
                end
            end
        end
    end

    task automatic update_fifo_outs();
        ctrl_empty = (cq.size() == 0);
        ctrl_dout  = (cq.size() > 0) ? cq[0] : '0;
        data_empty = (dq.size() == 0);
        data_dout  = (dq.size() > 0) ? dq[0] : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (cap_ctrl && cq.size() > 0) void'(cq.pop_front());
        if (cap_data && dq.size() > 0) begin
            void'(dq.pop_front());
            pops_total++;
        end
        if (cap_wlast) pend_b++;
        if (cap_b) begin
            m_bvalid = 1'b0;
            pend_b--;
        end
        if (!m_bvalid && pend_b > 0 && int'($urandom % 100) < p_b) begin
            m_bvalid = 1'b1;
            if (rq.size() > 0) m_bresp = rq.pop_front();
            else if (rand_resp && ($urandom % 4) == 0) m_bresp = 2'($urandom_range(1, 3));
            else m_bresp = 2'b00;
        end
        m_awready = !aw_hold_low && (int'($urandom % 100) < p_aw);
        m_wready  = int'($urandom % 100) < p_w;
        update_fifo_outs();
    endtask

    task automatic push_cmd(input int len, input logic [31:0] addr);
        logic [39:0] w;
        w = {8'(len), addr};
        cq.push_back(w);
        mcmd.push_back(w);
        update_fifo_outs();
    endtask

    task automatic push_data(input int n);
        logic [35:0] w;
        for (int i = 0; i < n; i++) begin
            w = {4'($urandom), 32'($urandom)};
            dq.push_back(w);
            mdata.push_back(w);
        end
        update_fifo_outs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cq.delete(); dq.delete(); mcmd.delete(); mdata.delete(); rq.delete();
        pend_b = 0;
        m_bvalid = 1'b0;
        update_fifo_outs();
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_inflight || cq.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", 64'(n >= budget), 64'(0));
    endtask

    task automatic wait_beats(input int k, input int budget);
        int n = 0;
        while (m_beats < k && n < budget) begin
            tick();
            n++;
        end
        chk("wait_beats_timeout", 64'(n >= budget), 64'(0));
    endtask

    initial begin
        int base_pops, base_aw, gap_hi, n_legal, len, n;
        logic [31:0] base_cnt, addr;

        // Reset state
        do_reset();
        tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_burst_cnt", 64'(burst_cnt), 64'(0));
        chk("rst_errs", 64'({err_len, err_resp, err_4k}), 64'(0));
        chk("rst_valids", 64'({m_awvalid, m_wvalid, m_bready, ctrl_rd_en, data_rd_en}), 64'(0));

        // 1: full 64-beat burst, slave always ready
        push_cmd(64, 32'h1000_0000);
        push_data(64);
        wait_idle(1000);
        chk("t1_awaddr", 64'(last_awaddr), 64'h1000_0000);
        chk("t1_awlen", 64'(last_awlen), 64'd63);
        chk("t1_beats", 64'(last_beats), 64'd64);
        chk("t1_burst_cnt", 64'(burst_cnt), 64'd1);
        chk("t1_pops", 64'(pops_total), 64'd64);

        // 2: short tail burst
        base_pops = pops_total;
        push_cmd(5, 32'h1000_1900);
        push_data(5);
        wait_idle(200);
        chk("t2_awlen", 64'(last_awlen), 64'd4);
        chk("t2_beats", 64'(last_beats), 64'd5);
        chk("t2_pops", 64'(pops_total - base_pops), 64'd5);
        chk("t2_burst_cnt", 64'(burst_cnt), 64'd2);

        // 3: awready held low, then random wready
        aw_hold_low = 1;
        push_cmd(16, 32'h4000_0040);
        push_data(16);
        n = 0;
        while (!m_inflight && n < 50) begin tick(); n++; end
        repeat (10) tick();
        chk("t3_aw_held", 64'(m_awvalid), 64'd1);
        chk("t3_no_w", 64'(m_wvalid), 64'd0);
        aw_hold_low = 0;
        p_w = 50;
        wait_idle(1000);
        chk("t3_awaddr", 64'(last_awaddr), 64'h4000_0040);
        chk("t3_beats", 64'(last_beats), 64'd16);

        // 4: data FIFO runs dry after 21 beats for 7 cycles
        p_w = 100;
        push_cmd(64, 32'h1000_2000);
        push_data(21);
        wait_beats(21, 500);
        gap_hi = 0;
        repeat (7) begin
            tick();
            if (m_wvalid) gap_hi++;
        end
        chk("t4_gap_wvalid", 64'(gap_hi), 64'd0);
        chk("t4_beats_held", 64'(m_beats), 64'd21);
        push_data(43);
        wait_idle(1000);
        chk("t4_beats", 64'(last_beats), 64'd64);
        chk("t4_no_err", 64'({err_len, err_resp, err_4k}), 64'd0);

        // 5: illegal lengths dropped, next command proceeds
        base_aw  = aw_count;
        base_cnt = burst_cnt;
        push_cmd(0, 32'h5000_0000);
        push_cmd(65, 32'h5000_0100);
        push_cmd(8, 32'h5000_0200);
        push_data(8);
        wait_idle(500);
        chk("t5_err_len", 64'(err_len), 64'd1);
        chk("t5_aw_count", 64'(aw_count - base_aw), 64'd1);
        chk("t5_burst_cnt", 64'(burst_cnt - base_cnt), 64'd1);
        chk("t5_awaddr", 64'(last_awaddr), 64'h5000_0200);

        // 6: SLVERR on the second burst, which also crosses a 4 KB page
        do_reset();
        rq.push_back(2'b00);
        rq.push_back(2'b10);
        push_cmd(8, 32'h3000_0000);
        push_cmd(32, 32'h0000_0FC0);
        push_data(40);
        wait_idle(1000);
        chk("t6_errs", 64'({err_len, err_resp, err_4k}), 64'b011);
        chk("t6_burst_cnt", 64'(burst_cnt), 64'd2);
        push_cmd(4, 32'h3000_1000);
        push_data(4);
        wait_idle(200);
        chk("t6_sticky", 64'({err_resp, err_4k}), 64'b11);
        do_reset();
        tick();
        chk("t6_cleared", 64'({err_len, err_resp, err_4k}), 64'd0);

        // Randomized traffic
        rand_resp = 1;
        n_legal = 0;
        for (int i = 0; i < 40; i++) begin
            p_aw = $urandom_range(30, 100);
            p_w  = $urandom_range(30, 100);
            p_b  = $urandom_range(30, 100);
            if (($urandom % 10) == 0) len = (($urandom % 2) == 0) ? 0 : $urandom_range(65, 255);
            else len = $urandom_range(1, 64);
            addr = $urandom & 32'hFFFF_FFFC;
            push_cmd(len, addr);
            if (len >= 1 && len <= 64) begin
                n_legal++;
                push_data(len);
            end
            repeat ($urandom_range(0, 20)) tick();
        end
        wait_idle(30000);
        chk("rand_burst_cnt", 64'(burst_cnt), 64'(n_legal));

        // Reset mid-burst aborts the transaction
        do_reset();
        rand_resp = 0;
        p_aw = 100; p_w = 100; p_b = 100;
        push_cmd(32, 32'h6000_0000);
        push_data(32);
        repeat (15) tick();
        chk("abort_busy_before", 64'(busy), 64'd1);
        do_reset();
        tick();
        chk("abort_busy_after", 64'(busy), 64'd0);
        chk("abort_wvalid", 64'(m_wvalid), 64'd0);
        push_cmd(4, 32'h6000_1000);
        push_data(4);
        wait_idle(200);
        chk("abort_recover_cnt", 64'(burst_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900_000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
